// File: rtl/b_block_xfer_pkg.sv
// Shared definitions for the B-register block-transfer sequencer (034/035),
// also used by the B register file and the memory port arbiter.
package b_block_xfer_pkg;

    localparam int DEF_AWIDTH   = 22;
    localparam int DEF_DWIDTH   = 64;
    localparam int DEF_BWIDTH   = 24;
    localparam int DEF_LOGDEPTH = 6;
    localparam int DEF_CWIDTH   = 7;

    localparam logic [5:0] OP_B_LOAD  = 6'o34;  // memory -> B
    localparam logic [5:0] OP_B_STORE = 6'o35;  // B -> memory

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_B_RD,
        ST_WR_REQ,
        ST_DONE
    } xfer_state_t;

endpackage

// File: rtl/b_block_xfer.sv
// Block-transfer sequencer: moves N words between memory (from A0) and
// consecutive B registers (from JK), one memory request outstanding at a time.
module b_block_xfer
    import b_block_xfer_pkg::*;
#(
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int BWIDTH   = DEF_BWIDTH,
    parameter int LOGDEPTH = DEF_LOGDEPTH,
    parameter int CWIDTH   = DEF_CWIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_dir,
    input  logic [LOGDEPTH-1:0] i_jk,
    input  logic [CWIDTH-1:0]   i_count,
    input  logic [AWIDTH-1:0]   i_base_addr,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [AWIDTH-1:0]   o_mem_addr,
    output logic [DWIDTH-1:0]   o_mem_wdata,
    input  logic                i_mem_ack,
    input  logic                i_mem_rvalid,
    input  logic [DWIDTH-1:0]   i_mem_rdata,
    output logic [LOGDEPTH-1:0] o_b_rd_addr,
    input  logic [BWIDTH-1:0]   i_b_rd_data,
    output logic                o_b_wr_en,
    output logic [LOGDEPTH-1:0] o_b_wr_addr,
    output logic [BWIDTH-1:0]   o_b_wr_data
);

    xfer_state_t         state, state_nxt;
    logic [AWIDTH-1:0]   cur_addr;
    logic [LOGDEPTH-1:0] cur_b;
    logic [CWIDTH-1:0]   remaining;
    logic                first_wr;
    logic [BWIDTH-1:0]   wdata_q;
    logic [BWIDTH-1:0]   wr_word;
    logic                advance;
    logic                last_word;
    logic                unused_rdata_hi;

    assign unused_rdata_hi = ^i_mem_rdata[DWIDTH-1:BWIDTH];

    assign advance   = ((state == ST_RD_WAIT) && i_mem_rvalid) ||
                       ((state == ST_WR_REQ) && i_mem_ack);
    assign last_word = (remaining == CWIDTH'(1));

    // Regfile data arrives in the first WR_REQ cycle; hold a copy for the rest of the wait.
    assign wr_word = first_wr ? i_b_rd_data : wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            cur_b     <= '0;
            remaining <= '0;
            first_wr  <= 1'b0;
        end else begin
            state    <= state_nxt;
            first_wr <= (state == ST_B_RD);
            if ((state == ST_IDLE) && i_start) begin
                cur_addr  <= i_base_addr;
                cur_b     <= i_jk;
                remaining <= i_count;
            end else if (advance) begin
                cur_addr  <= cur_addr + AWIDTH'(1);
                cur_b     <= cur_b + LOGDEPTH'(1);
                remaining <= remaining - CWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (first_wr) begin
            wdata_q <= i_b_rd_data;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_b_rd_addr = '0;
        o_b_wr_en   = 1'b0;
        o_b_wr_addr = '0;
        o_b_wr_data = '0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count == '0) begin
                        state_nxt = ST_DONE;
                    end else if (i_dir) begin
                        state_nxt = ST_B_RD;
                    end else begin
                        state_nxt = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                o_busy     = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_addr = cur_addr;
                if (i_mem_ack) begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                o_busy = 1'b1;
                if (i_mem_rvalid) begin
                    o_b_wr_en   = 1'b1;
                    o_b_wr_addr = cur_b;
                    o_b_wr_data = i_mem_rdata[BWIDTH-1:0];
                    state_nxt   = last_word ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_B_RD: begin
                o_busy      = 1'b1;
                o_b_rd_addr = cur_b;
                state_nxt   = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                o_busy      = 1'b1;
                o_b_rd_addr = cur_b;
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = cur_addr;
                o_mem_wdata = DWIDTH'(wr_word);
                if (i_mem_ack) begin
                    state_nxt = last_word ? ST_DONE : ST_B_RD;
                end
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_b_block_xfer.sv
// Scoreboard bench for b_block_xfer: random transfers against a word-level
// model, with a memory responder and a registered B register file.
module tb_b_block_xfer;

    localparam int AW = 22;
    localparam int DW = 64;
    localparam int BW = 24;
    localparam int LD = 6;
    localparam int CW = 7;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic [LD-1:0] addr;
        logic [BW-1:0] data;
    } bw_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic          i_dir;
    logic [LD-1:0] i_jk;
    logic [CW-1:0] i_count;
    logic [AW-1:0] i_base_addr;
    logic          o_busy;
    logic          o_done;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_ack;
    logic          i_mem_rvalid;
    logic [DW-1:0] i_mem_rdata;
    logic [LD-1:0] o_b_rd_addr;
    logic [BW-1:0] b_rd_data;
    logic          o_b_wr_en;
    logic [LD-1:0] o_b_wr_addr;
    logic [BW-1:0] o_b_wr_data;

    always #5 clk = ~clk;

    b_block_xfer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_dir       (i_dir),
        .i_jk        (i_jk),
        .i_count     (i_count),
        .i_base_addr (i_base_addr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata (i_mem_rdata),
        .o_b_rd_addr (o_b_rd_addr),
        .i_b_rd_data (b_rd_data),
        .o_b_wr_en   (o_b_wr_en),
        .o_b_wr_addr (o_b_wr_addr),
        .o_b_wr_data (o_b_wr_data)
    );

    // B register file: registered read, synchronous write
    bit [BW-1:0] b_regs [64];
    always @(posedge clk) begin
        if (o_b_wr_en) b_regs[o_b_wr_addr] <= o_b_wr_data;
        b_rd_data <= b_regs[o_b_rd_addr];
    end

    bit [BW-1:0] b_model [64];
    req_t        exp_req [$];
    bw_t         exp_bw  [$];
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    int          bw_cnt   = 0;
    int          ack_fix  = -1;
    int          rv_fix   = -1;
    bit          spur     = 1'b0;

    function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
        return {a ^ 22'h2AAAAA, a[19:0] ^ 20'hABCDE, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory responder: random or fixed ack latency, read data 1..3 cycles after ack
    initial begin
        int wcnt;
        int tgt;
        int rvc;
        logic [DW-1:0] rvd;
        wcnt = 0; tgt = 0; rvc = -1; rvd = '0;
        i_mem_ack = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            i_mem_ack    = 1'b0;
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = {$urandom, $urandom};
            if (!rst_n) begin
                wcnt = 0;
                rvc  = -1;
            end else begin
                if (rvc > 0) begin
                    rvc--;
                    if (rvc == 0) begin
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata  = rvd;
                        rvc          = -1;
                    end
                end
                if (o_mem_req) begin
                    if (wcnt == 0) tgt = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
                    if (wcnt >= tgt) begin
                        i_mem_ack = 1'b1;
                        wcnt      = 0;
                        if (!o_mem_we) begin
                            rvd = memfn(o_mem_addr);
                            rvc = (rv_fix >= 0) ? rv_fix : int'($urandom_range(1, 3));
                        end
                    end else begin
                        wcnt++;
                    end
                    if (spur && !o_mem_we) i_mem_rvalid = 1'b1;
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted request, B write and done pulse
    initial begin
        logic          preq;
        logic          pack;
        logic          pwe;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwd;
        req_t          r;
        bw_t           w;
        preq = 1'b0; pack = 1'b0; pwe = 1'b0; paddr = '0; pwd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                preq = 1'b0;
            end else begin
                if (preq && !pack) begin
                    check("req_hold", 64'({o_mem_req, o_mem_we, o_mem_addr}), 64'({1'b1, pwe, paddr}));
                    if (pwe) check("wdata_hold", o_mem_wdata, pwd);
                end
                if (o_mem_req && i_mem_ack) begin
                    if (exp_req.size() == 0) begin
                        check("req_extra", 64'(1), 64'(0));
                    end else begin
                        r = exp_req.pop_front();
                        check("req_we", 64'(o_mem_we), 64'(r.we));
                        check("req_addr", 64'(o_mem_addr), 64'(r.addr));
                        if (r.we) check("req_wdata", o_mem_wdata, r.wdata);
                    end
                end
                if (o_b_wr_en) begin
                    bw_cnt++;
                    if (exp_bw.size() == 0) begin
                        check("bwr_extra", 64'(1), 64'(0));
                    end else begin
                        w = exp_bw.pop_front();
                        check("bwr_addr", 64'(o_b_wr_addr), 64'(w.addr));
                        check("bwr_data", 64'(o_b_wr_data), 64'(w.data));
                    end
                end
                if (o_done) begin
                    done_cnt++;
                    check("done_drain", 64'(exp_req.size() + exp_bw.size()), 64'(0));
                    check("busy_at_done", 64'(o_busy), 64'(0));
                end
                preq  = o_mem_req;
                pack  = i_mem_ack;
                pwe   = o_mem_we;
                paddr = o_mem_addr;
                pwd   = o_mem_wdata;
            end
        end
    end

    task automatic start_xfer(input logic dir, input logic [LD-1:0] jk,
                              input logic [CW-1:0] cnt, input logic [AW-1:0] base);
        req_t r;
        bw_t  w;
        logic [DW-1:0] m;
        for (int i = 0; i < int'(cnt); i++) begin
            r.addr = base + AW'(i);
            w.addr = jk + LD'(i);
            if (!dir) begin
                m       = memfn(r.addr);
                r.we    = 1'b0;
                r.wdata = '0;
                w.data  = m[BW-1:0];
                b_model[w.addr] = w.data;
                exp_bw.push_back(w);
            end else begin
                r.we    = 1'b1;
                r.wdata = DW'(b_model[w.addr]);
            end
            exp_req.push_back(r);
        end
        @(negedge clk);
        i_dir = dir; i_jk = jk; i_count = cnt; i_base_addr = base; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_dir = 1'($urandom); i_jk = LD'($urandom); i_count = CW'($urandom); i_base_addr = AW'($urandom);
        #2;
        if (cnt == 0) check("zero_done_latency", 64'(o_done), 64'(1));
        else          check("busy_after_start", 64'(o_busy), 64'(1));
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
            @(negedge clk);
            #2;
        end
        check("done_seen", 64'(done_cnt - d0), 64'(1));
        @(negedge clk);
        #2;
        check("done_one_cycle", 64'({o_done, 32'(done_cnt - d0)}), 64'({1'b0, 32'd1}));
    endtask

    task automatic run(input logic dir, input logic [LD-1:0] jk, input logic [CW-1:0] cnt,
                       input logic [AW-1:0] base, input bit restart);
        int d0;
        d0 = done_cnt;
        start_xfer(dir, jk, cnt, base);
        if (restart) begin
            repeat (2) @(negedge clk);
            i_start = 1'b1; i_dir = ~dir; i_count = 7'd5; i_jk = jk + 6'd9;
            @(negedge clk);
            i_start = 1'b0;
        end
        wait_done(d0);
    endtask

    initial begin
        bit [BW-1:0]   snap [64];
        logic [DW-1:0] m;
        int            b0;
        bit            found;
        int            bad;

        rst_n = 1'b0; i_start = 1'b0; i_dir = 1'b0; i_jk = '0; i_count = '0; i_base_addr = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_ctrl", 64'({o_busy, o_done, o_mem_req, o_mem_we, o_b_wr_en}), 64'(0));
        check("reset_addr", 64'({o_mem_addr, o_b_rd_addr, o_b_wr_addr, o_b_wr_data}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // fill the B file with memory contents
        run(1'b0, 6'd0, 7'd64, 22'h12345, 1'b0);

        ack_fix = 1; rv_fix = 2;
        run(1'b0, 6'd5, 7'd3, 22'h100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            m = memfn(22'h100 + AW'(i));
            check("t1_breg", 64'(b_regs[5 + i]), 64'(m[BW-1:0]));
        end

        ack_fix = -1; rv_fix = -1;
        run(1'b1, 6'd62, 7'd4, 22'h3FFFFE, 1'b0);

        run(1'b0, 6'd10, 7'd0, 22'h200, 1'b0);
        run(1'b1, 6'd11, 7'd0, 22'h300, 1'b0);

        ack_fix = 5;
        run(1'b1, 6'd20, 7'd1, 22'h0ABCD, 1'b0);
        run(1'b1, 6'd21, 7'd2, 22'h1F000, 1'b0);

        // reset during word 2 of a 4-word load
        snap = b_model;
        ack_fix = 3; rv_fix = 1;
        b0 = bw_cnt;
        found = 1'b0;
        start_xfer(1'b0, 6'd12, 7'd4, 22'h2A000);
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            #2;
            if (bw_cnt >= b0 + 1 && o_mem_req) found = 1'b1;
        end
        check("rst_reach_word2", 64'(found), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", 64'({o_busy, o_done, o_mem_req, o_mem_we, o_b_wr_en}), 64'(0));
        check("rst_async_addr", 64'({o_mem_addr, o_b_rd_addr}), 64'(0));
        exp_req.delete();
        exp_bw.delete();
        b_model = snap;
        m = memfn(22'h2A000);
        b_model[12] = m[BW-1:0];
        repeat (2) @(negedge clk);
        check("rst_word1_kept", 64'(b_regs[12]), 64'(m[BW-1:0]));
        check("rst_word2_untouched", 64'(b_regs[13]), 64'(snap[13]));
        rst_n = 1'b1;
        ack_fix = -1; rv_fix = -1;
        run(1'b0, 6'd12, 7'd4, 22'h2B000, 1'b0);

        // stray start and stray rvalid
        spur = 1'b1;
        run(1'b0, 6'd30, 7'd6, 22'h33330, 1'b1);
        spur = 1'b0;
        run(1'b1, 6'd40, 7'd6, 22'h3FFFFD, 1'b1);

        for (int t = 0; t < 16; t++) begin
            run(1'($urandom), LD'($urandom), CW'($urandom_range(0, 80)), AW'($urandom), 1'b0);
        end
        run(1'b0, 6'd60, 7'd100, 22'h3FFFC0, 1'b0);
        run(1'b1, 6'd50, 7'd70, 22'h000010, 1'b0);

        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (b_regs[i] !== b_model[i]) bad++;
        end
        check("bfile_final_mismatches", 64'(bad), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
